// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and sequencer that shares a single
// uart_tx transmitter among NUM_REQ byte-producing requesters.
// Optional completion watchdog: define UART_ARB_TIMEOUT_EN to add the
// TIMEOUT_CYCLES counter and the err_timeout output.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int data_wd        = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*data_wd-1:0] req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       tx_start,
  output logic [data_wd-1:0]         din,
  input  logic                       tx_busy,
  input  logic                       tx_done
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                       err_timeout
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

  // Parameter sanity; these never elaborate for a legal configuration.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be within 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic               tx_done_q;
  logic               done_rise;
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic [data_wd-1:0] req_bytes [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Only a fresh 0->1 transition of tx_done marks frame completion.
  assign done_rise = tx_done & ~tx_done_q;

  // Unpack the flat request data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*data_wd +: data_wd];
    end
  end

  // Round-robin search: first pending requester after last_grant, modulo NUM_REQ.
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    cand       = '0;
    // Walk from the farthest candidate down so the nearest one is written last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx        = int'(last_grant) + k;
      idx        = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
      cand       = idx[ID_W-1:0];
      pick_valid = pick_valid | req[cand];
      pick_id    = req[cand] ? cand : pick_id;
    end
  end

  // Arbiter FSM: grant, launch, wait for completion, acknowledge and rotate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ack        <= '0;
      tx_start   <= 1'b0;
      din        <= '0;
      grant_id   <= '0;
      arb_busy   <= 1'b0;
      tx_done_q  <= 1'b0;
      last_grant <= LAST_ID;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      tx_done_q <= tx_done;
      ack       <= '0;
      tx_start  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // Never launch into a transmitter that is still shifting out a frame.
          if (pick_valid && !tx_busy) begin
            din      <= req_bytes[pick_id];
            grant_id <= pick_id;
            tx_start <= 1'b1;
            arb_busy <= 1'b1;
            state    <= S_LAUNCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (done_rise) begin
            ack   <= ACK_ONE << grant_id;
            state <= S_ACK;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (wd_cnt == WD_LAST) begin
            ack         <= ACK_ONE << grant_id;
            err_timeout <= 1'b1;
            state       <= S_ACK;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
`else
          end else begin
            state <= S_WAIT;
`endif
          end
        end
        S_ACK: begin
          last_grant <= grant_id;
          arb_busy   <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against an event-timestamp model.
// Define UART_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=50).
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 50;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   ack;
  logic [1:0]      grant_id;
  logic            arb_busy;
  logic            tx_start;
  logic [DW-1:0]   din;
  logic            tx_busy;
  logic            tx_done;
  logic            err_timeout;

  logic [DW-1:0]   bytes_v [NR];
  logic            auto_done, auto_busy, man_done;
  bit              auto_tx;
  int              tx_delay;
  int              tx_cnt;
  int              n_cmp, n_bad;

  assign req_data = {bytes_v[3], bytes_v[2], bytes_v[1], bytes_v[0]};
  assign tx_done  = auto_done | man_done;
  assign tx_busy  = auto_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .data_wd(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .arb_busy(arb_busy), .tx_start(tx_start), .din(din),
    .tx_busy(tx_busy), .tx_done(tx_done)
`ifdef UART_ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );
`ifndef UART_ARB_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench transmitter: tx_done pulses tx_delay cycles after it sees tx_start.
  initial begin
    logic s_start, s_rst;
    auto_done = 1'b0;
    auto_busy = 1'b0;
    tx_cnt    = 0;
    forever begin
      @(posedge clk);
      s_start = tx_start;
      s_rst   = rst;
      #1;
      if (s_rst) begin
        auto_done = 1'b0; auto_busy = 1'b0; tx_cnt = 0;
      end else if (s_start === 1'b1 && auto_tx) begin
        auto_busy = 1'b1; auto_done = 1'b0; tx_cnt = tx_delay;
      end else if (tx_cnt > 0) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt == 0) begin
          auto_done = 1'b1; auto_busy = 1'b0;
        end
      end else begin
        auto_done = 1'b0;
      end
    end
  end

  // Model: timestamps of the open frame's grant edge and completion edge.
  int      edge_n;
  int      g_edge, r_edge, m_last, m_id;
  logic [DW-1:0] m_data;
  bit      open_f, m_to, prev_done, model_valid;

  initial begin
    edge_n = 0; model_valid = 1'b0; open_f = 1'b0;
    g_edge = -100; r_edge = -1; m_last = NR - 1; m_id = 0; m_data = '0;
    m_to = 1'b0; prev_done = 1'b0;
  end

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      open_f = 1'b0; g_edge = -100; r_edge = -1; m_last = NR - 1;
      m_id = 0; m_data = '0; m_to = 1'b0; prev_done = 1'b0;
    end else begin
      if (open_f && r_edge >= 0 && edge_n == r_edge + 1) begin
        open_f = 1'b0;
        m_last = m_id;
      end else if (!open_f && req != '0) begin
        for (int k = NR; k >= 1; k--) begin
          if (req[(m_last + k) % NR]) m_id = (m_last + k) % NR;
        end
        m_data = bytes_v[m_id];
        open_f = 1'b1; g_edge = edge_n; r_edge = -1; m_to = 1'b0;
      end else if (open_f && r_edge < 0 && edge_n >= g_edge + 2) begin
        if (tx_done && !prev_done) begin
          r_edge = edge_n;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (edge_n == g_edge + 1 + TO) begin
          r_edge = edge_n; m_to = 1'b1;
`endif
        end
      end
      prev_done = tx_done;
    end
    model_valid = 1'b1;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [NR-1:0] e_ack;
    logic          e_start, e_busy, e_err;
    if (model_valid) begin
      e_ack   = (open_f && edge_n == r_edge) ? (4'b0001 << m_id) : 4'b0000;
      e_start = open_f && edge_n == g_edge;
      e_busy  = open_f;
      e_err   = open_f && edge_n == r_edge && m_to;
      n_cmp = n_cmp + 1;
      if (ack !== e_ack || tx_start !== e_start || arb_busy !== e_busy ||
          din !== m_data || grant_id !== m_id[1:0] || err_timeout !== e_err) begin
        n_bad = n_bad + 1;
        $display("FAIL model_cycle %0d: ack=%b/%b start=%b/%b busy=%b/%b din=%h/%h gid=%0d/%0d err=%b/%b (got/want)",
                 edge_n, ack, e_ack, tx_start, e_start, arb_busy, e_busy,
                 din, m_data, grant_id, m_id, err_timeout, e_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int exp_id);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1'b1;
    end
    chk("start_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("grant_id", 32'(grant_id), 32'(exp_id));
      chk("din", 32'(din), 32'(bytes_v[exp_id]));
    end
  endtask

  task automatic wait_ack(input int exp_id, input bit drop);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) seen = 1'b1;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("ack_vec", 32'(ack), 32'd1 << exp_id);
      if (drop) req[exp_id] = 1'b0;
    end
  endtask

  initial begin
    int fair_ids [6];
    int n_ack;
    bit seen;
    n_cmp = 0; n_bad = 0;
    bytes_v[0] = 8'h3C; bytes_v[1] = 8'h5A; bytes_v[2] = 8'hA5; bytes_v[3] = 8'hC3;
    fair_ids = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; req = '0; man_done = 1'b0; auto_tx = 1'b1; tx_delay = 20;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_start", 32'(tx_start), 32'h0);
    chk("rst_din", 32'(din), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(arb_busy), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);

    // Single request from requester 2 with byte 0xA5.
    @(posedge clk); #1 req = 4'b0100;
    wait_start(2);
    chk("t1_din_lit", 32'(din), 32'hA5);
    chk("t1_gid_lit", 32'(grant_id), 32'h2);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) seen = 1'b1;
    end
    chk("t1_done_seen", 32'(seen), 32'd1);
    chk("t1_ack_before", 32'(ack), 32'h0);
    @(negedge clk);
    chk("t1_ack", 32'(ack), 32'h4);
    req = '0;
    @(negedge clk);
    chk("t1_ack_after", 32'(ack), 32'h0);

    // Fairness from a fresh reset with all four requesters held high.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req = 4'b1111;
    for (int f = 0; f < 6; f++) begin
      wait_start(fair_ids[f]);
      wait_ack(fair_ids[f], 1'b0);
    end
    req = '0;

    // Skip and wrap: grant to 3, then only 1, then 0 and 2 together.
    req = 4'b1000;
    wait_start(3); wait_ack(3, 1'b1);
    req = 4'b0010;
    wait_start(1); wait_ack(1, 1'b1);
    req = 4'b0101;
    wait_start(2); wait_ack(2, 1'b1);
    wait_start(0); wait_ack(0, 1'b1);

    // Stale tx_done: level already high on entry to WAIT must not complete.
    auto_tx = 1'b0; man_done = 1'b1; req = 4'b0010;
    wait_start(1);
    n_ack = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) n_ack = n_ack + 1;
    end
    chk("stale_no_ack", 32'(n_ack), 32'h0);
    @(posedge clk); #1 man_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 man_done = 1'b1;
    wait_ack(1, 1'b1);
    man_done = 1'b0; auto_tx = 1'b1;

    // Reset five cycles into a frame; rotation restarts at requester 0.
    req = 4'b0100;
    wait_start(2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; req = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_start", 32'(tx_start), 32'h0);
    chk("mid_rst_din", 32'(din), 32'h0);
    chk("mid_rst_gid", 32'(grant_id), 32'h0);
    chk("mid_rst_busy", 32'(arb_busy), 32'h0);
    n_ack = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) n_ack = n_ack + 1;
    end
    chk("mid_rst_no_ack", 32'(n_ack), 32'h0);
    req = 4'b0101;
    wait_start(0); wait_ack(0, 1'b1);
    wait_start(2); wait_ack(2, 1'b1);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no tx_done at all; ack and err_timeout 50 cycles into WAIT.
    auto_tx = 1'b0;
    req = 4'b0011;
    wait_start(0);
    n_ack = 0; seen = 1'b0;
    for (int i = 1; i <= 80 && !seen; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        seen = 1'b1; n_ack = i;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_latency", 32'(n_ack), 32'd51);
    chk("to_ack", 32'(ack), 32'h1);
    chk("to_err", 32'(err_timeout), 32'h1);
    req[0] = 1'b0;
    wait_start(1); wait_ack(1, 1'b1);
    auto_tx = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
